parallax_layers: RTL and testbench

PARALLAX_LAYERS -- requirements
Module: parallax_layers

---
 rtl/parallax_layers_if.sv | 12 +
 rtl/parallax_layers.sv | 133 +++++++++++++
 tb/tb_parallax_layers.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/parallax_layers_if.sv
// Raster-position inputs and colour/frame outputs shared by the sync generator and parallax_layers.
interface parallax_layers_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       pause;
  logic [2:0] rgb;
  logic [7:0] frame;

  modport master (output hpos, vpos, display_on, pause, input rgb, frame);
  modport slave  (input hpos, vpos, display_on, pause, output rgb, frame);
endinterface

// File: rtl/parallax_layers.sv
// Star-field LFSR layers behind random-walk mountain silhouettes inside a square window.
// Build option: define PARALLAX_TWINKLE_EN to XOR star colours with frame[4:2].
module parallax_layers #(
  parameter int STAR_LAYERS  = 3,
  parameter int MOUNT_LAYERS = 2,
  parameter int WIN_BITS     = 8
) (
  input  logic              clk,
  input  logic              reset,
  parallax_layers_if.slave  bus
);

  localparam logic [9:0] WIN_SIZE = 10'(1 << WIN_BITS);

  function automatic logic [15:0] star_mask(int k);
    case (k)
      0:       return 16'hD008;
      1:       return 16'h6000;
      2:       return 16'h3802;
      default: return 16'h1C80;
    endcase
  endfunction

  function automatic logic [7:0] lfsr8_step(logic [7:0] l);
    return l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
  endfunction

  // Height walks up when the LFSR's outgoing bit is 1, down otherwise.
  function automatic logic [9:0] height_step(logic [9:0] h, logic up);
    return up ? h + 10'd1 : h - 10'd1;
  endfunction

  logic        w_win;
  logic [2:0]  w_twinkle;
  logic [2:0]  w_pix;
  logic [2:0]  r_rgb;
  logic [7:0]  r_frame;

  logic [15:0] r_star      [STAR_LAYERS];
  logic [15:0] w_star_next [STAR_LAYERS];
  logic [2:0]  w_star_col  [STAR_LAYERS];

  logic [7:0]  r_sh_l [MOUNT_LAYERS];
  logic [9:0]  r_sh_h [MOUNT_LAYERS];
  logic [7:0]  r_wk_l [MOUNT_LAYERS];
  logic [9:0]  r_wk_h [MOUNT_LAYERS];
  logic [MOUNT_LAYERS-1:0] w_cover;

  assign w_win     = (bus.hpos < WIN_SIZE) && (bus.vpos < WIN_SIZE);
  assign bus.rgb   = r_rgb;
  assign bus.frame = r_frame;

`ifdef PARALLAX_TWINKLE_EN
  assign w_twinkle = r_frame[4:2];
`else
  assign w_twinkle = 3'b000;
`endif

  // Layer k is (16-k) bits wide in a 16-bit slot; upper bits stay zero after reset.
  genvar gi;
  generate
    for (gi = 0; gi < STAR_LAYERS; gi++) begin : g_star
      localparam int         WID   = 16 - gi;
      localparam logic [9:0] HMASK = 10'((1 << gi) - 1);
      logic w_step;
      assign w_step = w_win && ((bus.hpos & HMASK) == 10'd0);
      assign w_star_next[gi] = !w_step        ? r_star[gi] :
                               r_star[gi][0]  ? ((r_star[gi] >> 1) ^ star_mask(gi)) :
                                                (r_star[gi] >> 1);
      assign w_star_col[gi]  = (&r_star[gi][WID-1:7]) ? (r_star[gi][2:0] ^ w_twinkle) : 3'b000;
    end
    for (gi = 0; gi < MOUNT_LAYERS; gi++) begin : g_cover
      assign w_cover[gi] = w_win && (r_wk_h[gi] < bus.vpos);
    end
  endgenerate

  always_comb begin
    w_pix = 3'b000;
    for (int k = 0; k < STAR_LAYERS; k++)
      w_pix = w_pix | w_star_col[k];
    for (int m = 0; m < MOUNT_LAYERS; m++)
      if (w_cover[m]) w_pix = 3'(2 * (m + 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAR_LAYERS; k++)
        r_star[k] <= 16'((32'd1 << (16 - k)) - 32'd1);
    end else begin
      for (int k = 0; k < STAR_LAYERS; k++)
        r_star[k] <= w_star_next[k];
    end
  end

  // Shadow pair advances m+1 times on the first row below the window; each row's
  // working pair restarts from it at the right window edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < MOUNT_LAYERS; m++) begin
        r_sh_l[m] <= 8'h60;
        r_sh_h[m] <= 10'(200 - 20 * m);
        r_wk_l[m] <= 8'h60;
        r_wk_h[m] <= 10'(200 - 20 * m);
      end
    end else begin
      for (int m = 0; m < MOUNT_LAYERS; m++) begin
        if ((bus.vpos == WIN_SIZE) && (bus.hpos <= 10'(m)) && !bus.pause) begin
          r_sh_l[m] <= lfsr8_step(r_sh_l[m]);
          r_sh_h[m] <= height_step(r_sh_h[m], r_sh_l[m][0]);
        end
        if (bus.hpos == WIN_SIZE) begin
          r_wk_l[m] <= r_sh_l[m];
          r_wk_h[m] <= r_sh_h[m];
        end else if (w_win) begin
          r_wk_l[m] <= lfsr8_step(r_wk_l[m]);
          r_wk_h[m] <= height_step(r_wk_h[m], r_wk_l[m][0]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rgb   <= 3'b000;
      r_frame <= 8'd0;
    end else begin
      r_rgb <= (bus.display_on && w_win) ? w_pix : 3'b000;
      if ((bus.hpos == 10'd0) && (bus.vpos == 10'd0) && !bus.pause)
        r_frame <= r_frame + 8'd1;
    end
  end

endmodule

// File: tb/tb_parallax_layers.sv
// Bench for parallax_layers: default build plus a 4-star/1-mountain/64x64 instance, both against a reference model.
module tb_parallax_layers;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  parallax_layers_if bus1();
  parallax_layers_if bus2();

  parallax_layers dut (.clk(clk), .reset(reset), .bus(bus1));
  parallax_layers #(.STAR_LAYERS(4), .MOUNT_LAYERS(1), .WIN_BITS(6))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0][15:0] star;
    logic [2:0][7:0]  sl;
    logic [2:0][9:0]  sh;
    logic [2:0][7:0]  wl;
    logic [2:0][9:0]  wh;
    logic [7:0]       frame;
    logic [2:0]       rgb;
  } mst_t;

  localparam logic [3:0][15:0] TAPS = {16'h1C80, 16'h3802, 16'h6000, 16'hD008};

  mst_t m1, m2;

  function automatic logic [15:0] galois(logic [15:0] x, logic [15:0] t);
    return x[0] ? ((x >> 1) ^ t) : (x >> 1);
  endfunction

  function automatic mst_t minit();
    mst_t s;
    s = '0;
    for (int k = 0; k < 4; k++) s.star[k] = 16'((32'd1 << (16 - k)) - 32'd1);
    for (int m = 0; m < 3; m++) begin
      s.sl[m] = 8'h60; s.wl[m] = 8'h60;
      s.sh[m] = 10'(200 - 20 * m); s.wh[m] = 10'(200 - 20 * m);
    end
    return s;
  endfunction

  // One pixel clock of the whole scene, evaluated from the current state.
  function automatic mst_t mstep(mst_t s, int ns, int nm, int wb, int h, int v, bit disp, bit pau);
    mst_t n;
    int side;
    bit win;
    logic [2:0] col, tw;
    n = s;
    side = 1 << wb;
    win = (h < side) && (v < side);
    tw = 3'b000;
`ifdef PARALLAX_TWINKLE_EN
    tw = s.frame[4:2];
`endif
    col = 3'b000;
    for (int k = 0; k < ns; k++)
      if ((int'(s.star[k]) >> 7) == ((1 << (9 - k)) - 1)) col = col | (s.star[k][2:0] ^ tw);
    for (int m = 0; m < nm; m++)
      if (win && int'(s.wh[m]) < v) col = 3'(2 * (m + 1));
    n.rgb = (disp && win) ? col : 3'b000;
    for (int k = 0; k < ns; k++)
      if (win && (h % (1 << k)) == 0) n.star[k] = galois(s.star[k], TAPS[k]);
    for (int m = 0; m < nm; m++) begin
      if (v == side && h <= m && !pau) begin
        n.sh[m] = s.sl[m][0] ? s.sh[m] + 10'd1 : s.sh[m] - 10'd1;
        n.sl[m] = 8'(galois({8'h00, s.sl[m]}, 16'h00B8));
      end
      if (h == side) begin
        n.wl[m] = s.sl[m];
        n.wh[m] = s.sh[m];
      end else if (win) begin
        n.wh[m] = s.wl[m][0] ? s.wh[m] + 10'd1 : s.wh[m] - 10'd1;
        n.wl[m] = 8'(galois({8'h00, s.wl[m]}, 16'h00B8));
      end
    end
    if (h == 0 && v == 0 && !pau) n.frame = s.frame + 8'd1;
    return n;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(int h, int v, bit d, bit p);
    bus1.hpos = 10'(h); bus1.vpos = 10'(v); bus1.display_on = d; bus1.pause = p;
    bus2.hpos = 10'(h); bus2.vpos = 10'(v); bus2.display_on = d; bus2.pause = p;
  endtask

  task automatic tick();
    @(posedge clk);
    m1 = mstep(m1, 3, 2, 8, int'(bus1.hpos), int'(bus1.vpos), bus1.display_on, bus1.pause);
    m2 = mstep(m2, 4, 1, 6, int'(bus2.hpos), int'(bus2.vpos), bus2.display_on, bus2.pause);
    #1;
    check("rgb1", 32'(bus1.rgb), 32'(m1.rgb));
    check("frame1", 32'(bus1.frame), 32'(m1.frame));
    check("star0", 32'(dut.r_star[0]), 32'(m1.star[0]));
    check("sh_h0", 32'(dut.r_sh_h[0]), 32'(m1.sh[0]));
    check("sh_h1", 32'(dut.r_sh_h[1]), 32'(m1.sh[1]));
    check("rgb2", 32'(bus2.rgb), 32'(m2.rgb));
    check("frame2", 32'(bus2.frame), 32'(m2.frame));
    check("star3_b", 32'(dut2.r_star[3]), 32'(m2.star[3]));
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    m1 = minit();
    m2 = minit();
    check("rst_rgb", 32'(bus1.rgb), 32'd0);
    check("rst_frame", 32'(bus1.frame), 32'd0);
    check("rst_star0", 32'(dut.r_star[0]), 32'hFFFF);
    check("rst_sh0", 32'(dut.r_sh_h[0]), 32'd200);
    check("rst_sh1", 32'(dut.r_sh_h[1]), 32'd180);
    check("rst_rgb2", 32'(bus2.rgb), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    $display("reset applied and released at t=%0t", $time);
  endtask

  // Compressed raster: full rows near the shadow row and every 32nd row, edges elsewhere.
  task automatic run_frame(bit pau);
    for (int v = 0; v < 258; v++)
      for (int h = 0; h < 260; h++)
        if (v % 32 == 0 || v >= 250 || h < 4 || h == 256) begin
          drive(h, v, 1'b1, pau);
          tick();
        end
    $display("frame pass pause=%0d frame=%0d", pau, bus1.frame);
  endtask

  typedef struct {
    int         h;
    int         v;
    bit         disp;
    bit         pau;
    bit         chk1;
    logic [2:0] exp1;
    bit         chk2;
    logic [2:0] exp2;
  } vec_t;

  vec_t tbl [17];

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    drive(0, 0, 1'b1, 1'b0);
    m1 = minit();
    m2 = minit();

    // First pixel after reset: all three star layers are all-ones, so colour 7.
    do_reset();
    tick();
    check("first_rgb", 32'(bus1.rgb), 32'd7);
    check("first_frame", 32'(bus1.frame), 32'd1);
    $display("first pixel rgb=%0d frame=%0d", bus1.rgb, bus1.frame);

    drive(0, 0, 1'b1, 1'b0);
    do_reset();
    run_frame(1'b0);
    run_frame(1'b0);
    check("two_frames", 32'(bus1.frame), 32'd2);
    check("m0_h_2steps", 32'(dut.r_sh_h[0]), 32'd198);
    check("m0_l_2steps", 32'(dut.r_sh_l[0]), 32'h18);
    check("m1_h_4steps", 32'(dut.r_sh_h[1]), 32'd176);
    check("m1_l_4steps", 32'(dut.r_sh_l[1]), 32'h06);

    drive(0, 0, 1'b1, 1'b1);
    do_reset();
    run_frame(1'b1);
    run_frame(1'b1);
    check("paused_frame", 32'(bus1.frame), 32'd0);
    check("paused_m0", 32'(dut.r_sh_h[0]), 32'd200);
    check("paused_m1", 32'(dut.r_sh_h[1]), 32'd180);

    // Reset in the middle of the shadow advance, then resume at hpos=1.
    drive(0, 0, 1'b1, 1'b0);
    do_reset();
    drive(0, 256, 1'b1, 1'b0);
    tick();
    check("adv_m0", 32'(dut.r_sh_h[0]), 32'd199);
    check("adv_m1", 32'(dut.r_sh_h[1]), 32'd179);
    do_reset();
    drive(1, 256, 1'b1, 1'b0);
    tick();
    check("resume_m0", 32'(dut.r_sh_h[0]), 32'd200);
    check("resume_m1", 32'(dut.r_sh_h[1]), 32'd179);
    $display("shadow abort sequence m0=%0d m1=%0d", dut.r_sh_h[0], dut.r_sh_h[1]);

    tbl[0]  = '{300, 10,  1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000};
    tbl[1]  = '{100, 20,  1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000};
    tbl[2]  = '{256, 0,   1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000};
    tbl[3]  = '{0,   256, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 3'b000};
    tbl[4]  = '{255, 255, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000};
    tbl[5]  = '{256, 255, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000};
    tbl[6]  = '{0,   255, 1'b1, 1'b0, 1'b1, 3'b100, 1'b1, 3'b000};
    tbl[7]  = '{256, 190, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000};
    tbl[8]  = '{0,   190, 1'b1, 1'b0, 1'b1, 3'b100, 1'b1, 3'b000};
    tbl[9]  = '{256, 180, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000};
    tbl[10] = '{0,   180, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000};
    tbl[11] = '{256, 181, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000};
    tbl[12] = '{0,   181, 1'b1, 1'b0, 1'b1, 3'b100, 1'b1, 3'b000};
    tbl[13] = '{64,  10,  1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000};
    tbl[14] = '{63,  10,  1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[15] = '{511, 511, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000};
    tbl[16] = '{65,  3,   1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000};

    drive(0, 0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].h, tbl[i].v, tbl[i].disp, tbl[i].pau);
      tick();
      if (tbl[i].chk1) check("vec_rgb1", 32'(bus1.rgb), 32'(tbl[i].exp1));
      if (tbl[i].chk2) check("vec_rgb2", 32'(bus2.rgb), 32'(tbl[i].exp2));
      $display("vec %0d h=%0d v=%0d disp=%0d pause=%0d rgb1=%0d rgb2=%0d",
               i, tbl[i].h, tbl[i].v, tbl[i].disp, tbl[i].pau, bus1.rgb, bus2.rgb);
    end

    // Full small raster for the 64x64 instance: exercises layer-3 stepping cadence.
    for (int f = 0; f < 2; f++) begin
      for (int v = 0; v < 70; v++)
        for (int h = 0; h < 80; h++) begin
          drive(h, v, 1'b1, 1'b0);
          tick();
        end
      $display("small raster frame=%0d star3=%0h", bus2.frame, dut2.r_star[3]);
    end

    for (int i = 0; i < 5000; i++) begin
      int h, v, sel;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) begin
        h = int'($urandom_range(0, 3)); v = 256;
      end else if (sel == 1) begin
        h = 0; v = 0;
      end else begin
        h = int'($urandom_range(0, 300)); v = int'($urandom_range(0, 300));
      end
      drive(h, v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
      bus2.hpos = 10'($urandom_range(0, 80));
      bus2.vpos = 10'($urandom_range(0, 70));
      tick();
    end
    $display("random phase done frame1=%0d frame2=%0d", bus1.frame, bus2.frame);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
